mips_fwd_unit: RTL and testbench

Parametrised hazard and forwarding tracker for the mips789 pipeline. It supersedes the fixed three-stage forwarding logic and supports a configurable number of tracked post-decode stages and source operands. It also detects load-use hazards and inserts bubbles itself. It sits beside the decoder: it takes decode-stage register numbers and drives the operand forward muxes and the decode stall.

---
 rtl/mips_fwd_if.sv | 29 ++
 rtl/mips_fwd_unit.sv | 124 ++++++++++++
 tb/tb_mips_fwd_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_fwd_if.sv
// Decode-side bus of the mips789 hazard/forwarding tracker.
// The decoder drives the master side; mips_fwd_unit takes the slave side.
interface mips_fwd_if #(
  parameter int RN_W  = 5,
  parameter int NSTG  = 3,
  parameter int NSRC  = 2,
  parameter int SEL_W = 2
);
  logic                   pause;
  logic                   flush;
  logic [RN_W-1:0]        id_rd_i;
  logic                   id_we_i;
  logic                   id_ld_i;
  logic [NSRC*RN_W-1:0]   id_rs_i;
  logic [NSRC*SEL_W-1:0]  fw_sel_o;
  logic                   stall_o;
  logic [NSTG*RN_W-1:0]   stg_rd_o;
  logic [NSTG-1:0]        stg_we_o;

  modport master (
    output pause, flush, id_rd_i, id_we_i, id_ld_i, id_rs_i,
    input  fw_sel_o, stall_o, stg_rd_o, stg_we_o
  );

  modport slave (
    input  pause, flush, id_rd_i, id_we_i, id_ld_i, id_rs_i,
    output fw_sel_o, stall_o, stg_rd_o, stg_we_o
  );
endinterface

// File: rtl/mips_fwd_unit.sv
// Parametrised hazard/forwarding tracker: shift chain of post-decode destinations,
// per-source forward selects and load-use stall. Load-use detection: LOAD_STALL_EN.
module mips_fwd_unit #(
  parameter int RN_W   = 5,
  parameter int NSTG   = 3,
  parameter int NSRC   = 2,
  parameter int SEL_W  = 2,
  parameter int LD_STG = 2
) (
  input logic        clk,
  input logic        rst,
  mips_fwd_if.slave  bus
);

  logic [RN_W-1:0] rd_reg [1:NSTG];
  logic [NSTG:1]   we_reg;
  logic [NSRC-1:0] lu_hit;
  logic            stall;
  logic            bubble;
  logic [RN_W-1:0] rd_next;
  logic            we_next;

  assign stall  = |lu_hit;
  assign bubble = stall | bus.flush;

  // r0 writes are dropped here so nothing downstream ever matches register 0
  assign rd_next = bubble ? '0 : bus.id_rd_i;
  assign we_next = bubble ? 1'b0 : (bus.id_we_i & (bus.id_rd_i != '0));

  genvar gi;
  generate
    for (gi = 1; gi <= NSTG; gi++) begin : g_stg
      if (gi == 1) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rd_reg[gi] <= '0;
            we_reg[gi] <= 1'b0;
          end else if (!bus.pause) begin
            rd_reg[gi] <= rd_next;
            we_reg[gi] <= we_next;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            rd_reg[gi] <= '0;
            we_reg[gi] <= 1'b0;
          end else if (!bus.pause) begin
            rd_reg[gi] <= rd_reg[gi-1];
            we_reg[gi] <= we_reg[gi-1];
          end
        end
      end
      assign bus.stg_rd_o[(gi-1)*RN_W +: RN_W] = rd_reg[gi];
      assign bus.stg_we_o[gi-1]                = we_reg[gi];
    end
  endgenerate

`ifdef LOAD_STALL_EN
  logic [NSTG:1] ld_reg;
  logic          ld_next;

  assign ld_next = bubble ? 1'b0 : (bus.id_ld_i & bus.id_we_i);

  generate
    for (gi = 1; gi <= NSTG; gi++) begin : g_ld
      if (gi == 1) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst)              ld_reg[gi] <= 1'b0;
          else if (!bus.pause)  ld_reg[gi] <= ld_next;
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst)              ld_reg[gi] <= 1'b0;
          else if (!bus.pause)  ld_reg[gi] <= ld_reg[gi-1];
        end
      end
    end
  endgenerate
`else
  // Loads forward like ALU results; the MIPS I delay slot covers the gap.
  logic unused_cfg;
  assign unused_cfg = bus.id_ld_i ^ (LD_STG > 0);
`endif

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [RN_W-1:0]  rs;
      logic [SEL_W-1:0] hit_k;
      logic             hit_ld;

      assign rs = bus.id_rs_i[gi*RN_W +: RN_W];

      // Scan oldest to youngest so the youngest matching stage overwrites.
      always_comb begin
        hit_k  = '0;
        hit_ld = 1'b0;
        if (rs != '0) begin
          for (int k = NSTG; k >= 1; k--) begin
            if (we_reg[k] && (rd_reg[k] == rs)) begin
              hit_k = SEL_W'(k);
`ifdef LOAD_STALL_EN
              hit_ld = ld_reg[k];
`endif
            end
          end
        end
      end

`ifdef LOAD_STALL_EN
      assign lu_hit[gi] = hit_ld && (hit_k != '0) && (32'(hit_k) < LD_STG);
`else
      logic unused_ld;
      assign unused_ld  = hit_ld;
      assign lu_hit[gi] = 1'b0;
`endif

      assign bus.fw_sel_o[gi*SEL_W +: SEL_W] = lu_hit[gi] ? '0 : hit_k;
    end
  endgenerate

  assign bus.stall_o = stall;

endmodule

// File: tb/tb_mips_fwd_unit.sv
// Directed bench for mips_fwd_unit (default parameters); expectations follow LOAD_STALL_EN.
module tb_mips_fwd_unit;

`ifdef LOAD_STALL_EN
  localparam bit LSE = 1'b1;
`else
  localparam bit LSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mips_fwd_if bus ();

  mips_fwd_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) $display("check %-12s observed=%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    bus.id_rd_i = rd;
    bus.id_we_i = we;
    bus.id_ld_i = ld;
    bus.id_rs_i = {rs1, rs0};
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.pause = 1'b0;
    bus.flush = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #11;
    chk("rst_sel",   32'(bus.fw_sel_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o),  32'd0);
    chk("rst_we",    32'(bus.stg_we_o), 32'd0);
    chk("rst_rd",    32'(bus.stg_rd_o), 32'd0);
    rst = 1'b0;

    // forward ageing of r5
    drive(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive(5'd0, 1'b0, 1'b0, 5'd5, 5'd0);
    chk("age_rd1", 32'(bus.stg_rd_o), 32'd5);
    chk("age_we1", 32'(bus.stg_we_o), 32'b001);
    chk("age_k1",  32'(bus.fw_sel_o[1:0]), 32'd1);
    step();
    chk("age_k2",  32'(bus.fw_sel_o[1:0]), 32'd2);
    step();
    chk("age_k3",  32'(bus.fw_sel_o[1:0]), 32'd3);
    step();
    chk("age_gone", 32'(bus.fw_sel_o[1:0]), 32'd0);

    // youngest writer wins
    drive(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    step();
    drive(5'd0, 1'b0, 1'b0, 5'd7, 5'd7);
    chk("young_both", 32'(bus.fw_sel_o), 32'b0101);

    // r0 never tracked
    drive(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
    chk("r0_we",   32'(bus.stg_we_o[0]), 32'd0);
    chk("r0_sel",  32'(bus.fw_sel_o[1:0]), 32'd0);
    chk("r0_age7", 32'(bus.fw_sel_o[3:2]), 32'd2);
    step(); step(); step();

    // load-use on source 1
    drive(5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
    step();
    drive(5'd10, 1'b1, 1'b0, 5'd0, 5'd9);
    chk("lu_stall", 32'(bus.stall_o),        LSE ? 32'd1 : 32'd0);
    chk("lu_sel",   32'(bus.fw_sel_o[3:2]),  LSE ? 32'd0 : 32'd1);
    step();
    chk("lu_we",    32'(bus.stg_we_o),       LSE ? 32'b010 : 32'b011);
    chk("lu_stall2", 32'(bus.stall_o),       32'd0);
    chk("lu_sel2",  32'(bus.fw_sel_o[3:2]),  32'd2);
    drive(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step(); step(); step();

    // build a known chain: stage1=6, stage2=4, stage3=3
    drive(5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive(5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive(5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    bus.pause = 1'b1;
    drive(5'd8, 1'b1, 1'b0, 5'd4, 5'd0);
    chk("chain_rd", 32'(bus.stg_rd_o), 32'({5'd3, 5'd4, 5'd6}));
    chk("chain_we", 32'(bus.stg_we_o), 32'b111);
    chk("pause_sel", 32'(bus.fw_sel_o[1:0]), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pause_rd", 32'(bus.stg_rd_o), 32'({5'd3, 5'd4, 5'd6}));
      chk("pause_we", 32'(bus.stg_we_o), 32'b111);
    end

    bus.pause = 1'b0;
    bus.flush = 1'b1;
    step();
    chk("flush_rd",  32'(bus.stg_rd_o), 32'({5'd4, 5'd6, 5'd0}));
    chk("flush_we",  32'(bus.stg_we_o), 32'b110);
    chk("flush_sel", 32'(bus.fw_sel_o[1:0]), 32'd3);

    bus.pause = 1'b1;
    step();
    chk("pf_rd", 32'(bus.stg_rd_o), 32'({5'd4, 5'd6, 5'd0}));
    chk("pf_we", 32'(bus.stg_we_o), 32'b110);

    bus.pause = 1'b0;
    bus.flush = 1'b0;
    step();
    chk("resume_rd",  32'(bus.stg_rd_o), 32'({5'd6, 5'd0, 5'd8}));
    chk("resume_we",  32'(bus.stg_we_o), 32'b101);
    chk("resume_old", 32'(bus.fw_sel_o[1:0]), 32'd0);
    drive(5'd0, 1'b0, 1'b0, 5'd8, 5'd6);
    chk("resume_sel", 32'(bus.fw_sel_o), 32'b1101);

    // asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sel",   32'(bus.fw_sel_o), 32'd0);
    chk("arst_stall", 32'(bus.stall_o),  32'd0);
    chk("arst_we",    32'(bus.stg_we_o), 32'd0);
    chk("arst_rd",    32'(bus.stg_rd_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
